// File: rtl/data_mem_banked.sv
// Handshaked data memory with configurable read latency and byte-lane writes.
// Define DMEM_BOUNDS_CHECK_EN to flag out-of-range addresses instead of wrapping.
module data_mem_banked #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              is_read;
  logic              err_q;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] rd_now;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              in_range;

  // Contents survive rst; only the power-on value is zero.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign accept = req && (state == IDLE);
  assign idx    = addr[IDX_W-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  assign in_range = (32'(addr) < DEPTH_U);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;
  assign in_range = 1'b1;
`endif

  assign rd_now = in_range ? mem[idx] : '0;
  assign ready  = (state == IDLE);
  assign done   = (state == RESP);
  assign err    = (state == RESP) && err_q;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = (we || RD_LAT == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      is_read <= 1'b0;
      err_q   <= 1'b0;
      rd_buf  <= '0;
      rdata   <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        is_read <= !we;
        err_q   <= !in_range;
        rd_buf  <= rd_now;
        cnt     <= CNT_W'(RD_LAT - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      // rdata changes only when a read enters RESP; single-cycle reads bypass rd_buf.
      if (next_state == RESP && (accept ? !we : is_read))
        rdata <= accept ? rd_now : rd_buf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && we && in_range) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

endmodule
